// File: rtl/solution.sv
// solution -- full adder plus a bit-serial adder that shares its operand pins.
//
// Combinational section (no clock or reset involvement):
//   a, b, cin   addend bits and carry-in
//   sum, cout   full-adder sum and carry-out
//
// Serial section (clk rising edge, rst_n asynchronous active-low):
//   ser_start   load carry from cin, clear the result and counter, enter RUN
//   ser_en      consume one {a,b} bit pair this cycle (RUN only)
//   ser_sum     a ^ b ^ carry_q, the bit consumed on this edge
//   ser_result  WIDTH-bit sum, shifted in from the MSB so the first bit lands at [0]
//   ser_cout    final carry of the last completed addition
//   ser_busy    high while an addition is in progress
//   ser_done    one-cycle pulse on the cycle after the last bit is consumed
module solution #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  input  logic             cin,
  output logic             sum,
  output logic             cout,
  input  logic             ser_start,
  input  logic             ser_en,
  output logic             ser_sum,
  output logic [WIDTH-1:0] ser_result,
  output logic             ser_cout,
  output logic             ser_busy,
  output logic             ser_done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic          carry_q;
  logic          carry_nxt;
  logic [CW-1:0] cnt;

  // Full adder: purely combinational, independent of every serial register.
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

  assign ser_sum   = a ^ b ^ carry_q;
  assign carry_nxt = (a & b) | (a & carry_q) | (b & carry_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      carry_q    <= 1'b0;
      cnt        <= '0;
      ser_result <= '0;
      ser_cout   <= 1'b0;
      ser_busy   <= 1'b0;
      ser_done   <= 1'b0;
    end else begin
      ser_done <= 1'b0;
      // Start has priority over ser_en: a restart never consumes a bit.
      if (ser_start) begin
        state      <= RUN;
        carry_q    <= cin;
        cnt        <= '0;
        ser_result <= '0;
        ser_busy   <= 1'b1;
      end else if (state == RUN && ser_en) begin
        ser_result <= {ser_sum, ser_result[WIDTH-1:1]};
        carry_q    <= carry_nxt;
        if (cnt == LAST) begin
          state    <= IDLE;
          cnt      <= '0;
          ser_busy <= 1'b0;
          ser_cout <= carry_nxt;
          ser_done <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_solution.sv
module tb_solution;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a, b, cin;
  logic       sum, cout;
  logic       ser_start, ser_en;
  logic       ser_sum;
  logic [7:0] ser_result;
  logic       ser_cout, ser_busy, ser_done;

  int nvec = 0;
  int nerr = 0;

  // Expected completions: {cout, result}
  logic [8:0] expq[$];

  solution #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin), .sum(sum), .cout(cout),
    .ser_start(ser_start), .ser_en(ser_en), .ser_sum(ser_sum),
    .ser_result(ser_result), .ser_cout(ser_cout), .ser_busy(ser_busy), .ser_done(ser_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every ser_done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (ser_done === 1'b1) begin
      if (expq.size() == 0) begin
        nvec++; nerr++;
        $display("FAIL unexpected_done: got ser_done=1 result=0x%0h expected no completion", ser_result);
      end else begin
        logic [8:0] e;
        e = expq.pop_front();
        check("ser_result", {24'd0, ser_result}, {24'd0, e[7:0]});
        check("ser_cout", {31'd0, ser_cout}, {31'd0, e[8]});
        check("busy_at_done", {31'd0, ser_busy}, 32'd0);
      end
    end
  end

  task automatic start(input logic c);
    ser_start = 1'b1; ser_en = 1'b0; cin = c;
    @(posedge clk); #1;
    ser_start = 1'b0;
    check("start_busy", {31'd0, ser_busy}, 32'd1);
    check("start_clear", {24'd0, ser_result}, 32'd0);
  endtask

  // Feed bits [0..nbits-1]; optional 3-cycle pause after bit index pause_at.
  task automatic feed(input logic [7:0] x, input logic [7:0] y, input int nbits, input int pause_at);
    for (int i = 0; i < nbits; i++) begin
      a = x[i]; b = y[i]; ser_en = 1'b1;
      @(posedge clk); #1;
      if (i == pause_at) begin
        ser_en = 1'b0;
        repeat (3) begin
          a = 1'($urandom); b = 1'($urandom);
          @(posedge clk); #1;
        end
      end
    end
    ser_en = 1'b0;
  endtask

  task automatic add(input logic [7:0] x, input logic [7:0] y, input logic c,
                     input logic [8:0] exp, input int pause_at);
    start(c);
    expq.push_back(exp);
    feed(x, y, 8, pause_at);
    check("done_timing", {31'd0, ser_done}, 32'd1);
    check("busy_after", {31'd0, ser_busy}, 32'd0);
  endtask

  localparam logic [1:0] FA_EXP [8] = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};

  initial begin
    rst_n = 1'b0; a = 0; b = 0; cin = 0; ser_start = 0; ser_en = 0;

    // Full adder, all 8 combinations, held in reset.
    for (int i = 0; i < 8; i++) begin
      {a, b, cin} = 3'(i);
      #10;
      check("fa_sum_cout", {30'd0, sum, cout}, {30'd0, FA_EXP[i]});
    end

    check("reset_result", {24'd0, ser_result}, 32'd0);
    check("reset_busy", {31'd0, ser_busy}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    add(8'h5A, 8'h3C, 1'b0, 9'h096, -1);
    add(8'hFF, 8'h01, 1'b0, 9'h100, -1);
    add(8'hFF, 8'h00, 1'b1, 9'h100, -1);
    add(8'h5A, 8'h3C, 1'b0, 9'h096, 3);

    // Asynchronous reset mid-run: no completion is queued for this one.
    start(1'b1);
    feed(8'hFF, 8'hFF, 4, -1);
    ser_en = 1'b1;
    #2 rst_n = 1'b0;
    a = 1'b1; b = 1'b0; cin = 1'b1;
    #1;
    check("rst_result", {24'd0, ser_result}, 32'd0);
    check("rst_cout", {31'd0, ser_cout}, 32'd0);
    check("rst_busy", {31'd0, ser_busy}, 32'd0);
    check("rst_done", {31'd0, ser_done}, 32'd0);
    check("rst_fa", {30'd0, sum, cout}, 32'd1);
    repeat (2) @(posedge clk);
    #1; ser_en = 1'b0; rst_n = 1'b1;

    add(8'h12, 8'h34, 1'b0, 9'h046, -1);

    // IDLE ignores ser_en.
    a = 1'b1; b = 1'b1; ser_en = 1'b1;
    repeat (3) @(posedge clk);
    #1; ser_en = 1'b0;
    check("idle_result", {24'd0, ser_result}, 32'h46);
    check("idle_busy", {31'd0, ser_busy}, 32'd0);

    // Restart during RUN with ser_en high: no bit consumed at the restart edge.
    start(1'b0);
    feed(8'hFF, 8'hFF, 3, -1);
    ser_start = 1'b1; ser_en = 1'b1; a = 1'b1; b = 1'b1; cin = 1'b1;
    @(posedge clk); #1;
    ser_start = 1'b0; ser_en = 1'b0;
    check("restart_clear", {24'd0, ser_result}, 32'd0);
    check("restart_busy", {31'd0, ser_busy}, 32'd1);
    a = 1'b1; b = 1'b0; #1;
    check("restart_ser_sum", {31'd0, ser_sum}, 32'd0);
    expq.push_back(9'h011);
    feed(8'h0F, 8'h01, 8, -1);
    check("done_timing", {31'd0, ser_done}, 32'd1);

    add(8'hA5, 8'h5A, 1'b1, 9'h100, -1);

    // Bounded drain of the scoreboard.
    for (int t = 0; t < 20 && expq.size() != 0; t++) @(posedge clk);
    @(negedge clk);
    check("queue_empty", expq.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
